imem_loader: RTL
================

# imem_loader

Boot-time program loader that fills the instruction memory over a byte-stream interface while the core is held off. It accepts a little-endian byte stream through a valid/ready handshake and packs each group of four bytes into a 32-bit instruction. Each packed instruction goes out through a single-cycle write port addressed exactly like the fetch-side `read_address`. It sits between the host/debug byte source and the instruction memory's write port, and it drives `cpu_hold` to the core.

## Interface

Parameters:
- `MAX_WORDS`, 15, maximum instructions per load.
- `BASE_ADDR`, 4, byte address of the first instruction; later words go at `BASE_ADDR + 4*i`.
- `ADDR_W`, 32, width of `mem_addr`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a load; honoured only in IDLE.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  stream byte.
- `in_last`  in  1  marks the final byte of the program; qualified by `in_valid`.
- `in_ready`  out  1  loader can accept a byte.
- `mem_we`  out  1  instruction-memory write enable, one cycle per word.
- `mem_addr`  out  ADDR_W  byte address of the write.
- `mem_wdata`  out  32  instruction word.
- `cpu_hold`  out  1  keeps the core stalled/in reset.
- `done`  out  1  one-cycle pulse when a load completes.
- `word_count`  out  $clog2(MAX_WORDS+1)  number of words written in the current or last load.
- `err_partial`  out  1  sticky; the last load ended mid-word.
- `err_overflow`  out  1  sticky; bytes arrived beyond `MAX_WORDS` words.

## Operation

- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - `in_ready`=0.
  - `start` moves the FSM to RECV, clears `word_count`, the byte counter, `err_partial` and `err_overflow`.
- RECV:
  - `in_ready`=1.
  - Each accepted byte (`in_valid & in_ready` at a rising edge) shifts into the packer at lane `byte_cnt` (lane 0 = bits 7:0).
  - On the 4th byte, or on a byte with `in_last`, the FSM moves to WRITE.
- WRITE:
  - `mem_we`=1 for exactly one cycle.
  - `mem_addr = BASE_ADDR + 4*word_count`, `mem_wdata` = packed word.
  - Then `word_count` increments and `byte_cnt` clears.
  - The next state is DONE if the word ended with `in_last`, otherwise RECV.
- Partial word (`in_last` on lane 0–2):
  - Unfilled upper lanes are written as 0.
  - `err_partial` is set and the word is still written.
- Overflow: once `word_count == MAX_WORDS`:
  - Further bytes are still accepted (`in_ready`=1) and discarded.
  - No writes are issued and `err_overflow` is set.
  - `in_last` still moves the FSM to DONE.
- DONE: `done`=1 for one cycle, `cpu_hold` drops, and the FSM returns to IDLE.
- `cpu_hold`: 1 from reset until the first DONE; set again by every accepted `start`.
- The loader never clears memory. Locations not written keep their contents.

## Timing

- Reset values:
  - state IDLE.
  - `in_ready`=0, `mem_we`=0, `mem_addr`=`BASE_ADDR`, `mem_wdata`=0.
  - `cpu_hold`=1, `done`=0, `word_count`=0, both error flags 0.
- `start` in cycle N gives `in_ready`=1 in cycle N+1.
- The 4th byte accepted at edge N gives `mem_we`=1 during cycle N+1. `in_ready`=0 during WRITE.
- Sustained throughput: 4 bytes per 5 cycles.
- Final write in cycle N gives `done` in cycle N+1, and `cpu_hold`=0 from cycle N+2.
- `start` outside IDLE is ignored.
- `in_valid` without `in_ready` is ignored, and the byte is not consumed.
- `reset` mid-load returns every output to its reset value on the next edge. Partially written memory is left as is.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure

- Shared package `imem_pkg`:
  - FSM state enum.
  - `IMEM_WORD_W`=32.
  - `BASE_ADDR` and `MAX_WORDS` defaults, shared with the instruction memory.
- Sub-module `byte_packer`:
  - 4-lane byte register with lane counter, zero-fill on clear, and a `full`/`last_seen` indication.
- The FSM, address generation and flags live in `imem_loader`.

## Test plan

- Bytes 0x23,0x22,0xE1,0x02 with `in_last` on the last byte: exactly one `mem_we`, `mem_addr`=4, `mem_wdata`=0x02E12223, `done` one cycle later, `cpu_hold` falls, `word_count`=1.
- 3 words back-to-back with `in_valid` held high: writes to addresses 4, 8, 12, `in_ready` low for exactly one cycle after each 4th byte, `word_count`=3.
- `in_last` on the 2nd byte of word 1 (0xAA,0xBB): write to 8 with 0x0000BBAA, `err_partial`=1.
- `MAX_WORDS`=15 and 16 words sent: 15 writes (last address 60), the 16th word is discarded, `err_overflow`=1, `done` still pulses.
- `reset` asserted after 6 bytes: next cycle outputs are at reset values. A new `start` then loads from address 4 with cleared flags.
- Random `in_valid` gaps plus `start` pulses during RECV: data and addresses are unchanged vs the gap-free run, and the stray `start` has no effect.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction memory.
package imem_pkg;

  localparam int unsigned IMEM_WORD_W    = 32;
  localparam int unsigned IMEM_BASE_ADDR = 4;
  localparam int unsigned IMEM_MAX_WORDS = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// Four-lane little-endian byte packer; clear zero-fills every lane so short words read back 0 above the last byte.
module byte_packer
  import imem_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   last,
  input  logic [7:0]             data,
  output logic [IMEM_WORD_W-1:0] word,
  output logic [2:0]             byte_cnt,
  output logic                   full,
  output logic                   last_seen
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word      <= '0;
      byte_cnt  <= '0;
      full      <= 1'b0;
      last_seen <= 1'b0;
    end else if (push) begin
      word[{byte_cnt[1:0], 3'b000} +: 8] <= data;
      byte_cnt  <= byte_cnt + 3'd1;
      full      <= (byte_cnt == 3'd3);
      last_seen <= last;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: packs a byte stream into 32-bit words and writes them to instruction memory while holding the core.
module imem_loader
  import imem_pkg::*;
#(
  parameter  int unsigned MAX_WORDS = IMEM_MAX_WORDS,
  parameter  int unsigned BASE_ADDR = IMEM_BASE_ADDR,
  parameter  int unsigned ADDR_W    = 32,
  localparam int unsigned WC_W      = $clog2(MAX_WORDS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [IMEM_WORD_W-1:0] mem_wdata,
  output logic                   cpu_hold,
  output logic                   done,
  output logic [WC_W-1:0]        word_count,
  output logic                   err_partial,
  output logic                   err_overflow
);

  state_t            state, state_nxt;
  logic [WC_W-1:0]   wc_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              part_nxt, ovf_nxt, hold_nxt;
  logic              pk_clear, accept, push, overflow;
  logic [2:0]        byte_cnt;
  logic              pk_full, pk_last;

  assign accept   = in_valid & in_ready;
  assign overflow = (word_count == WC_W'(MAX_WORDS));
  assign push     = accept & ~overflow;
  assign addr_nxt = ADDR_W'(BASE_ADDR) + (ADDR_W'(wc_nxt) << 2);

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .push      (push),
    .last      (in_last),
    .data      (in_data),
    .word      (mem_wdata),
    .byte_cnt  (byte_cnt),
    .full      (pk_full),
    .last_seen (pk_last)
  );

  // State and registered outputs; outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= ADDR_W'(BASE_ADDR);
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      word_count   <= '0;
      err_partial  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_nxt;
      in_ready     <= (state_nxt == ST_RECV);
      mem_we       <= (state_nxt == ST_WRITE);
      mem_addr     <= addr_nxt;
      cpu_hold     <= hold_nxt;
      done         <= (state_nxt == ST_DONE);
      word_count   <= wc_nxt;
      err_partial  <= part_nxt;
      err_overflow <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wc_nxt    = word_count;
    part_nxt  = err_partial;
    ovf_nxt   = err_overflow;
    hold_nxt  = cpu_hold;
    pk_clear  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RECV;
          wc_nxt    = '0;
          part_nxt  = 1'b0;
          ovf_nxt   = 1'b0;
          hold_nxt  = 1'b1;
          pk_clear  = 1'b1;
        end
      end
      ST_RECV: begin
        if (accept) begin
          // Past the word limit bytes are swallowed; only in_last still matters.
          if (overflow) begin
            ovf_nxt = 1'b1;
            if (in_last) state_nxt = ST_DONE;
          end else if (in_last || byte_cnt == 3'd3) begin
            state_nxt = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        wc_nxt   = word_count + WC_W'(1);
        pk_clear = 1'b1;
        if (pk_last && !pk_full) part_nxt = 1'b1;
        state_nxt = pk_last ? ST_DONE : ST_RECV;
      end
      ST_DONE: begin
        hold_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
